// File: rtl/arbiter_1_to_n_response_queued.sv
// arbiter_1_to_n_response_queued: routes queued memory responses to N requestor queues by a decoded route mask (optional ARBITER_RESPONSE_DROP_COUNT_EN adds dropped_count).
module arbiter_1_to_n_response_queued #(
  parameter int NUM_MEMORY_REQUESTOR = 4,
  parameter int ID_LEVEL = 1,
  parameter int IN_FIFO_DEPTH = 32,
  parameter int OUT_FIFO_DEPTH = 4,
  parameter int PROG_THRESH = 16,
  parameter int DATA_W = 32,
  localparam int N = NUM_MEMORY_REQUESTOR,
  localparam int PKT_W = DATA_W + 80
) (
  input  logic                 ap_clk,
  input  logic                 areset,
  input  logic                 response_in_valid,
  input  logic [PKT_W-1:0]     response_in_payload,
  input  logic [N-1:0]         fifo_response_signals_in_rd_en,
  output logic                 fifo_response_signals_out_full,
  output logic                 fifo_response_signals_out_prog_full,
  output logic                 fifo_response_signals_out_empty,
  output logic                 fifo_response_signals_out_valid,
  output logic                 fifo_response_signals_out_rst_busy,
  output logic [N-1:0]         response_out_valid,
  output logic [N*PKT_W-1:0]   response_out_payload,
  output logic                 fifo_setup_signal
`ifdef ARBITER_RESPONSE_DROP_COUNT_EN
  ,
  output logic [15:0]          dropped_count
`endif
);
  localparam int IAW = $clog2(IN_FIFO_DEPTH);
  localparam int OAW = $clog2(OUT_FIFO_DEPTH);
  localparam int FIELD = ID_LEVEL > 4 ? 0 : ID_LEVEL;
  localparam logic [IAW:0] ICNT_MAX = (IAW+1)'(IN_FIFO_DEPTH);
  localparam logic [IAW:0] IPROG = (IAW+1)'(PROG_THRESH);
  localparam logic [OAW:0] OCNT_MAX = (OAW+1)'(OUT_FIFO_DEPTH);
  typedef enum logic [1:0] {SETUP, DISPATCH, STALL} state_t;
  state_t state_q, state_d;
  logic in_v_q;
  logic [PKT_W-1:0] in_p_q;
  logic [PKT_W-1:0] in_mem_q [IN_FIFO_DEPTH];
  logic [IAW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [IAW:0] in_cnt_q, in_cnt_d;
  logic [PKT_W-1:0] out_mem_q [N][OUT_FIFO_DEPTH];
  logic [OAW-1:0] out_wp_q [N];
  logic [OAW-1:0] out_wp_d [N];
  logic [OAW-1:0] out_rp_q [N];
  logic [OAW-1:0] out_rp_d [N];
  logic [OAW:0] out_cnt_q [N];
  logic [OAW:0] out_cnt_d [N];
  logic [PKT_W-1:0] out_p_q [N];
  logic [PKT_W-1:0] out_p_d [N];
  logic [N-1:0] out_v_q;
  logic [1:0] busy_cnt_q, busy_cnt_d;
  logic [4:0] stat_q, stat_d;
  logic setup_q;
  logic busy, head_v, blocked, in_pop, in_push;
  logic [N-1:0] mask, space, out_pop, out_push;
  logic [PKT_W-1:0] head;
  // Head decode and per-queue space; a same-cycle pop counts as space.
  always_comb begin
    busy = busy_cnt_q != 2'd0;
    head = in_mem_q[in_rp_q];
    head_v = in_cnt_q != '0;
    mask = ID_LEVEL == 5 ? '1 : head[DATA_W + 16*FIELD +: N];
    for (int i = 0; i < N; i++) begin
      out_pop[i] = fifo_response_signals_in_rd_en[i] & (out_cnt_q[i] != '0);
      space[i] = (out_cnt_q[i] < OCNT_MAX) | out_pop[i];
    end
    blocked = |(mask & ~space);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SETUP:    state_d = busy ? SETUP : DISPATCH;
      DISPATCH: state_d = head_v & blocked ? STALL : DISPATCH;
      STALL:    state_d = blocked ? STALL : DISPATCH;
      default:  state_d = SETUP;
    endcase
  end
  always_comb begin
    in_pop = (state_q == DISPATCH) & head_v & ~blocked;
    out_push = in_pop ? mask : '0;
    in_push = in_v_q & ~busy & ((in_cnt_q < ICNT_MAX) | in_pop);
    in_wp_d = in_wp_q + IAW'(in_push);
    in_rp_d = in_rp_q + IAW'(in_pop);
    in_cnt_d = in_cnt_q + (IAW+1)'(in_push) - (IAW+1)'(in_pop);
    for (int i = 0; i < N; i++) begin
      out_wp_d[i] = out_wp_q[i] + OAW'(out_push[i]);
      out_rp_d[i] = out_rp_q[i] + OAW'(out_pop[i]);
      out_cnt_d[i] = out_cnt_q[i] + (OAW+1)'(out_push[i]) - (OAW+1)'(out_pop[i]);
      out_p_d[i] = out_pop[i] ? out_mem_q[i][out_rp_q[i]] : out_p_q[i];
    end
    stat_d = {(in_cnt_q == ICNT_MAX) | busy, in_cnt_q >= IPROG, in_cnt_q == '0, in_cnt_q != '0, busy};
    busy_cnt_d = busy ? busy_cnt_q - 2'd1 : 2'd0;
  end
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q <= SETUP;
      in_v_q <= 1'b0;
      in_wp_q <= '0;
      in_rp_q <= '0;
      in_cnt_q <= '0;
      for (int i = 0; i < N; i++) begin
        out_wp_q[i] <= '0;
        out_rp_q[i] <= '0;
        out_cnt_q[i] <= '0;
      end
      out_v_q <= '0;
      busy_cnt_q <= 2'd3;
      stat_q <= 5'b10101;
      setup_q <= 1'b1;
    end else begin
      state_q <= state_d;
      in_v_q <= response_in_valid;
      in_wp_q <= in_wp_d;
      in_rp_q <= in_rp_d;
      in_cnt_q <= in_cnt_d;
      for (int i = 0; i < N; i++) begin
        out_wp_q[i] <= out_wp_d[i];
        out_rp_q[i] <= out_rp_d[i];
        out_cnt_q[i] <= out_cnt_d[i];
      end
      out_v_q <= out_pop;
      busy_cnt_q <= busy_cnt_d;
      stat_q <= stat_d;
      setup_q <= busy;
    end
  end
  // Payload storage is deliberately left out of reset.
  always_ff @(posedge ap_clk) begin
    in_p_q <= response_in_payload;
    if (in_push) in_mem_q[in_wp_q] <= in_p_q;
    for (int i = 0; i < N; i++) begin
      if (out_push[i]) out_mem_q[i][out_wp_q[i]] <= head;
      out_p_q[i] <= out_p_d[i];
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++) response_out_payload[i*PKT_W +: PKT_W] = out_p_q[i];
  end
  assign response_out_valid = out_v_q;
  assign fifo_setup_signal = setup_q | (state_q == SETUP);
  assign {fifo_response_signals_out_full, fifo_response_signals_out_prog_full,
          fifo_response_signals_out_empty, fifo_response_signals_out_valid,
          fifo_response_signals_out_rst_busy} = stat_q;
`ifdef ARBITER_RESPONSE_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q} + 17'(in_pop & (mask == '0)) + 17'(in_v_q & ~in_push);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  always_ff @(posedge ap_clk) drop_cnt_q <= areset ? 16'd0 : drop_cnt_d;
  assign dropped_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_arbiter_1_to_n_response_queued.sv
// tb_arbiter_1_to_n_response_queued: queue-level reference model with per-cycle comparison plus directed scenarios.
module tb_arbiter_1_to_n_response_queued;
  localparam int PW = 112;
  logic ap_clk = 1'b0;
  logic areset, vin;
  logic [PW-1:0] pin;
  logic [3:0] rd;
  logic full, prog_full, empty, hvalid, rst_busy, fifo_setup_signal;
  logic [3:0] response_out_valid;
  logic [4*PW-1:0] response_out_payload;
`ifdef ARBITER_RESPONSE_DROP_COUNT_EN
  logic [15:0] dropped_count;
`endif
  arbiter_1_to_n_response_queued dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .response_in_valid(vin),
    .response_in_payload(pin),
    .fifo_response_signals_in_rd_en(rd),
    .fifo_response_signals_out_full(full),
    .fifo_response_signals_out_prog_full(prog_full),
    .fifo_response_signals_out_empty(empty),
    .fifo_response_signals_out_valid(hvalid),
    .fifo_response_signals_out_rst_busy(rst_busy),
    .response_out_valid(response_out_valid),
    .response_out_payload(response_out_payload),
    .fifo_setup_signal(fifo_setup_signal)
`ifdef ARBITER_RESPONSE_DROP_COUNT_EN
    ,
    .dropped_count(dropped_count)
`endif
  );
  always #5 ap_clk = ~ap_clk;
  int tests = 0, fails = 0;
  int seen [4];
  logic [PW-1:0] iq [$];
  logic [PW-1:0] oq [4][$];
  logic [PW-1:0] e_pay [4];
  logic [3:0] e_valid;
  logic [4:0] e_stat;
  logic e_setup, rv, stalled;
  logic [PW-1:0] rp;
  int left;
  logic [15:0] e_drop;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] sat(logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction
  function automatic logic [PW-1:0] pkt(logic [3:0] m, logic [31:0] d);
    logic [PW-1:0] p;
    p = {16'($urandom), $urandom, $urandom, $urandom};
    p[31:0] = d;
    p[51:48] = m;
    return p;
  endfunction
  // Reference: one clock edge of queue behaviour from the observable rules.
  task automatic step();
    logic [3:0] pop, space, m;
    logic busy, ok;
    logic [PW-1:0] p;
    if (areset) begin
      iq.delete();
      for (int i = 0; i < 4; i++) oq[i].delete();
      rv = 1'b0; left = 4; stalled = 1'b0; e_valid = '0; e_setup = 1'b1;
      e_stat = 5'b10101; e_drop = '0;
      return;
    end
    busy = left > 1;
    e_stat = {iq.size() == 32 || busy, iq.size() >= 16, iq.size() == 0, iq.size() != 0, busy};
    for (int i = 0; i < 4; i++) begin
      pop[i] = rd[i] && oq[i].size() != 0;
      space[i] = oq[i].size() < 4 || pop[i];
      e_valid[i] = pop[i];
      if (pop[i]) e_pay[i] = oq[i].pop_front();
    end
    if (left == 0 && iq.size() != 0) begin
      m = iq[0][51:48];
      ok = (m & ~space) == 4'd0;
      if (stalled) stalled = !ok;
      else if (!ok) stalled = 1'b1;
      else begin
        p = iq.pop_front();
        for (int i = 0; i < 4; i++) if (m[i]) oq[i].push_back(p);
        if (m == 4'd0) e_drop = sat(e_drop);
      end
    end
    if (rv && !busy && iq.size() < 32) iq.push_back(rp);
    else if (rv) e_drop = sat(e_drop);
    rv = vin; rp = pin;
    if (left > 0) left--;
    e_setup = left != 0;
  endtask
  task automatic cycle();
    @(posedge ap_clk);
    step();
    @(negedge ap_clk);
    chk("out_valid", response_out_valid, e_valid);
    for (int i = 0; i < 4; i++) begin
      if (e_valid[i]) chk("out_payload", response_out_payload[i*PW +: PW], e_pay[i]);
      if (response_out_valid[i] === 1'b1) seen[i]++;
    end
    chk("setup", fifo_setup_signal, e_setup);
    chk("in_status", {full, prog_full, empty, hvalid, rst_busy}, e_stat);
`ifdef ARBITER_RESPONSE_DROP_COUNT_EN
    chk("dropped_count", dropped_count, e_drop);
`endif
  endtask
  task automatic send(logic [PW-1:0] p);
    vin = 1'b1; pin = p;
    cycle();
    vin = 1'b0;
  endtask
  task automatic clear_seen();
    for (int i = 0; i < 4; i++) seen[i] = 0;
  endtask
  logic [PW-1:0] p0;
  initial begin
    areset = 1'b1; vin = 1'b0; pin = '0; rd = 4'hF;
    clear_seen();
    repeat (3) cycle();
    chk("rst_valid", response_out_valid, 4'd0);
    chk("rst_setup", fifo_setup_signal, 1'b1);
    chk("rst_status", {full, prog_full, empty, hvalid, rst_busy}, 5'b10101);
    areset = 1'b0;
    repeat (6) cycle();
    chk("setup_released", fifo_setup_signal, 1'b0);
    // unicast to requestor 2
    p0 = pkt(4'b0100, 32'hA5A5_0001);
    send(p0);
    repeat (2) cycle();
    chk("uni_early", response_out_valid, 4'd0);
    cycle();
    chk("uni_valid", response_out_valid, 4'b0100);
    chk("uni_payload", response_out_payload[2*PW +: PW], p0);
    // multicast to 0,1,3
    p0 = pkt(4'b1011, 32'h5A5A_0002);
    send(p0);
    repeat (3) cycle();
    chk("mc_valid", response_out_valid, 4'b1011);
    chk("mc_pay0", response_out_payload[0 +: PW], p0);
    chk("mc_pay1", response_out_payload[PW +: PW], p0);
    chk("mc_pay3", response_out_payload[3*PW +: PW], p0);
    cycle();
    chk("mc_once", response_out_valid, 4'd0);
    // stalled head blocks the following req1 packet
    rd = 4'b1110; clear_seen();
    for (int k = 0; k < 6; k++) send(pkt(4'b0001, 32'h100 + k));
    send(pkt(4'b0010, 32'h200));
    repeat (20) cycle();
    chk("hol_req0_held", seen[0], 0);
    chk("hol_req1_behind", seen[1], 0);
    chk("hol_inq_empty", empty, 1'b0);
    rd = 4'hF;
    repeat (20) cycle();
    chk("hol_req0_drained", seen[0], 6);
    chk("hol_req1_drained", seen[1], 1);
    // full non-destination queue must not block
    rd = 4'b1110; clear_seen();
    for (int k = 0; k < 4; k++) send(pkt(4'b0001, 32'h300 + k));
    send(pkt(4'b0010, 32'h400));
    repeat (15) cycle();
    chk("nohol_req1", seen[1], 1);
    chk("nohol_req0", seen[0], 0);
    rd = 4'hF;
    repeat (10) cycle();
    // zero mask is discarded
    clear_seen();
    send(pkt(4'b0000, 32'h500));
    repeat (8) cycle();
    chk("zero_no_valid", seen[0] + seen[1] + seen[2] + seen[3], 0);
`ifdef ARBITER_RESPONSE_DROP_COUNT_EN
    chk("zero_dropped", dropped_count, 16'd1);
`endif
    // randomized traffic, including an input-queue flood
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 600; c++) begin
        vin = seg == 1 ? 1'b1 : 1'($urandom_range(0, 1));
        pin = pkt(4'($urandom), $urandom);
        rd = seg == 1 ? ($urandom_range(0, 7) == 0 ? 4'($urandom) : 4'd0) : 4'($urandom);
        cycle();
      end
    end
    vin = 1'b0; rd = 4'hF;
    repeat (100) cycle();
    // reset with packets buffered
    rd = 4'd0;
    for (int k = 0; k < 10; k++) send(pkt(4'($urandom_range(1, 15)), 32'h600 + k));
    repeat (2) cycle();
    areset = 1'b1;
    cycle();
    chk("mrst_valid", response_out_valid, 4'd0);
    chk("mrst_setup", fifo_setup_signal, 1'b1);
    areset = 1'b0; rd = 4'hF; clear_seen();
    cycle();
    chk("mrst_setup_hold", fifo_setup_signal, 1'b1);
    repeat (20) cycle();
    chk("mrst_no_stale", seen[0] + seen[1] + seen[2] + seen[3], 0);
    chk("mrst_ready", fifo_setup_signal, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
